// File: rtl/div_share_ctrl_if.sv
// Requester-side bundle for the shared divide controller.
// Operand request and result response channels, one lane per requester.
interface div_share_ctrl_if #(
  parameter int NUM_REQ = 2,
  parameter int DW      = 16
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*DW-1:0] req_num;
  logic [NUM_REQ*DW-1:0] req_den;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [DW:0]           rsp_data;

  modport master (
    output req_valid,
    output req_num,
    output req_den,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_num,
    input  req_den,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/div_share_ctrl.sv
// Round-robin sequencer for one shared multicycle divide unit.
// Optional zero-denominator bypass: define DIV_SHARE_ZERO_DET_EN.
module div_share_ctrl #(
  parameter int NUM_REQ  = 2,
  parameter int DIV_WAIT = 2,
  parameter int DW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  div_share_ctrl_if.slave bus,
  output logic [DW-1:0] div_num,
  output logic [DW-1:0] div_den,
  input  logic [DW:0]   div_out,
`ifdef DIV_SHARE_ZERO_DET_EN
  output logic          div_zero_err,
`endif
  output logic          busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (DIV_WAIT > 1) ? $clog2(DIV_WAIT) : 1;
  localparam logic [CW-1:0] CNT_INIT  = CW'(DIV_WAIT - 1);
  localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [DW-1:0] num_q, num_d;
  logic [DW-1:0] den_q, den_d;
  logic [DW:0]   data_q, data_d;

  logic [GW-1:0]      pick;
  logic               pick_vld;
  int                 idx;
  logic [DW-1:0]      num_sel;
  logic [DW-1:0]      den_sel;
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] valid;
  logic               accept;

`ifdef DIV_SHARE_ZERO_DET_EN
  logic zero_q, zero_d;
`endif

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_q) + i) % NUM_REQ;
      if (!pick_vld && bus.req_valid[GW'(idx)]) begin
        pick_vld = 1'b1;
        pick     = GW'(idx);
      end
    end
  end

  always_comb begin
    num_sel = '0;
    den_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == GW'(i)) begin
        num_sel = bus.req_num[i*DW +: DW];
        den_sel = bus.req_den[i*DW +: DW];
      end
    end
  end

  // Accept is masked during reset so stale valids are not taken.
  always_comb begin
    ready = '0;
    if (state_q == S_IDLE && !rst && pick_vld) begin
      ready[pick] = 1'b1;
    end
  end

  assign accept = |ready;

  always_comb begin
    valid = '0;
    if (state_q == S_RESP) begin
      valid[grant_q] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    last_d  = last_q;
    num_d   = num_q;
    den_d   = den_q;
    data_d  = data_q;
`ifdef DIV_SHARE_ZERO_DET_EN
    zero_d  = zero_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          grant_d = pick;
          last_d  = pick;
`ifdef DIV_SHARE_ZERO_DET_EN
          if (den_sel == '0) begin
            data_d  = {1'b0, {DW{1'b1}}};
            zero_d  = 1'b1;
            state_d = S_RESP;
          end else begin
            num_d   = num_sel;
            den_d   = den_sel;
            cnt_d   = CNT_INIT;
            zero_d  = 1'b0;
            state_d = S_WAIT;
          end
`else
          num_d   = num_sel;
          den_d   = den_sel;
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
`endif
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          data_d  = div_out;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready[grant_q]) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      last_q  <= LAST_INIT;
      num_q   <= '0;
      den_q   <= '0;
      data_q  <= '0;
`ifdef DIV_SHARE_ZERO_DET_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      num_q   <= num_d;
      den_q   <= den_d;
      data_q  <= data_d;
`ifdef DIV_SHARE_ZERO_DET_EN
      zero_q  <= zero_d;
`endif
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = valid;
  assign bus.rsp_data  = data_q;
  assign div_num       = num_q;
  assign div_den       = den_q;
  assign busy          = (state_q != S_IDLE);

`ifdef DIV_SHARE_ZERO_DET_EN
  assign div_zero_err  = zero_q && (state_q == S_RESP);
`endif

endmodule
